// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB3 bridge: one serialised APB transfer per accepted AHB transfer.
// Optional feature macro AHB2APB_SLVERR_EN maps PSLVERR onto a two-cycle AHB ERROR response.
module ahb2apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PADDR_W = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [1:0]          HTRANS,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic                HWRITE,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [DATA_W-1:0]   HRDATA,
    output logic [PADDR_W-1:0]  PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
`ifdef AHB2APB_SLVERR_EN
        ,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
`endif
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                can_accept_s;
    logic                accept_s;
    logic                rd_capture_s;
    logic                hreadyout_nxt_s;
    logic                psel_nxt_s;
    logic                penable_nxt_s;
    logic                hreadyout_r;
    logic                psel_r;
    logic                penable_r;
    logic                pwrite_r;
    logic [PADDR_W-1:0]  paddr_r;
    logic [DATA_W-1:0]   pwdata_r;
    logic [DATA_W-1:0]   hrdata_r;
    logic                unused_bits_s;
`ifdef AHB2APB_SLVERR_EN
    logic                hresp_nxt_s;
    logic                hresp_r;
`endif

    // Accept window, next-state selection and read-data capture strobe
    always_comb begin
        can_accept_s = 1'b0;
        state_nxt_s  = state_r;
        case (state_r)
            ST_IDLE:  can_accept_s = 1'b1;
            ST_DONE:  can_accept_s = 1'b1;
`ifdef AHB2APB_SLVERR_EN
            ST_ERR2:  can_accept_s = 1'b1;
`endif
            default:  can_accept_s = 1'b0;
        endcase
        accept_s     = can_accept_s & HSEL & HTRANS[1] & HREADY;
        rd_capture_s = (state_r == ST_ACCESS) & PREADY & ~pwrite_r;

        case (state_r)
            ST_WDATA:  state_nxt_s = ST_SETUP;
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
`ifdef AHB2APB_SLVERR_EN
                    if (PSLVERR) begin
                        state_nxt_s = ST_ERR1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
`ifdef AHB2APB_SLVERR_EN
            ST_ERR1:   state_nxt_s = ST_ERR2;
`endif
            // IDLE, DONE, ERR2 and any illegal encoding: illegal ones never accept
            default: begin
                if (accept_s) begin
                    if (HWRITE) begin
                        state_nxt_s = ST_WDATA;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
        endcase
    end

    // Output values decoded from the next state so the outputs can be registered
    always_comb begin
        hreadyout_nxt_s = 1'b0;
        psel_nxt_s      = 1'b0;
        penable_nxt_s   = 1'b0;
`ifdef AHB2APB_SLVERR_EN
        hresp_nxt_s     = 1'b0;
`endif
        case (state_nxt_s)
            ST_IDLE:   hreadyout_nxt_s = 1'b1;
            ST_DONE:   hreadyout_nxt_s = 1'b1;
            ST_SETUP:  psel_nxt_s      = 1'b1;
            ST_ACCESS: begin
                psel_nxt_s    = 1'b1;
                penable_nxt_s = 1'b1;
            end
`ifdef AHB2APB_SLVERR_EN
            ST_ERR1:   hresp_nxt_s = 1'b1;
            ST_ERR2: begin
                hreadyout_nxt_s = 1'b1;
                hresp_nxt_s     = 1'b1;
            end
`endif
            default:   hreadyout_nxt_s = 1'b0;
        endcase
    end

    // State and handshake output registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= hreadyout_nxt_s;
            psel_r      <= psel_nxt_s;
            penable_r   <= penable_nxt_s;
        end
    end

`ifdef AHB2APB_SLVERR_EN
    // Error response register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hresp_r <= 1'b0;
        end else begin
            hresp_r <= hresp_nxt_s;
        end
    end
    assign HRESP = hresp_r;
`else
    assign HRESP = 1'b0;
`endif

    // Address/data capture; captured values stay frozen for the whole APB transfer
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_r  <= '0;
            pwrite_r <= 1'b0;
            pwdata_r <= '0;
            hrdata_r <= '0;
        end else begin
            if (accept_s) begin
                paddr_r  <= HADDR[PADDR_W-1:0];
                pwrite_r <= HWRITE;
            end
            if (state_r == ST_WDATA) begin
                pwdata_r <= HWDATA;
            end
            if (rd_capture_s) begin
                hrdata_r <= PRDATA;
            end
        end
    end

`ifdef AHB2APB_SLVERR_EN
    assign unused_bits_s = ^{HADDR[ADDR_W-1:PADDR_W], HTRANS[0]};
`else
    assign unused_bits_s = ^{HADDR[ADDR_W-1:PADDR_W], HTRANS[0], PSLVERR};
`endif

    assign HREADYOUT = hreadyout_r;
    assign HRDATA    = hrdata_r;
    assign PADDR     = paddr_r;
    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: each directed transfer is expanded into its expected per-cycle
// output timeline, which a single compare process checks on every falling edge.
module tb_ahb2apb_bridge;

`ifdef AHB2APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [15:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    ahb2apb_bridge dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        logic        psel;
        logic        penable;
        logic        hrdy;
        logic        hresp;
        logic [15:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_paddr  = 16'h0;
    logic        m_pwrite = 1'b0;
    logic [31:0] m_pwdata = 32'h0;
    logic [31:0] m_hrdata = 32'h0;
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_e(input logic ps, input logic pe, input logic hr, input logic rs,
                          input logic [15:0] pa, input logic pw,
                          input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        e.psel = ps; e.penable = pe; e.hrdy = hr; e.hresp = rs;
        e.paddr = pa; e.pwrite = pw; e.pwdata = wd; e.hrdata = rd;
        q.push_back(e);
    endtask

    // compare process: one expected entry per cycle, idle outputs when nothing is pending
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (chk_en) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                end else begin
                    e.psel = 1'b0; e.penable = 1'b0; e.hrdy = 1'b1; e.hresp = 1'b0;
                    e.paddr = m_paddr; e.pwrite = m_pwrite;
                    e.pwdata = m_pwdata; e.hrdata = m_hrdata;
                end
                chk("PSEL",      {31'b0, PSEL},      {31'b0, e.psel});
                chk("PENABLE",   {31'b0, PENABLE},   {31'b0, e.penable});
                chk("HREADYOUT", {31'b0, HREADYOUT}, {31'b0, e.hrdy});
                chk("HRESP",     {31'b0, HRESP},     {31'b0, e.hresp});
                chk("PADDR",     {16'b0, PADDR},     {16'b0, e.paddr});
                chk("PWRITE",    {31'b0, PWRITE},    {31'b0, e.pwrite});
                chk("PWDATA",    PWDATA,             e.pwdata);
                chk("HRDATA",    HRDATA,             e.hrdata);
            end
        end
    end

    task automatic idle_inputs();
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HREADY = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5A5A_5A5A;
    endtask

    // Called just after a rising edge; returns just after the edge that starts DONE/ERR2.
    task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic err,
                        output int lat);
        int          a;
        int          wr;
        int          last;
        logic [31:0] nw;
        logic [31:0] nh;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = w; HREADY = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5A5A_5A5A;
        a  = cyc;
        wr = w ? 1 : 0;
        @(negedge HCLK);
        #1;
        nw = w ? wdata : m_pwdata;
        nh = w ? m_hrdata : rdata;
        if (w) push_e(1'b0, 1'b0, 1'b0, 1'b0, addr[15:0], w, m_pwdata, m_hrdata);
        push_e(1'b1, 1'b0, 1'b0, 1'b0, addr[15:0], w, nw, m_hrdata);
        for (int i = 0; i <= waits; i++) push_e(1'b1, 1'b1, 1'b0, 1'b0, addr[15:0], w, nw, m_hrdata);
        if (err && SLVERR_EN) begin
            push_e(1'b0, 1'b0, 1'b0, 1'b1, addr[15:0], w, nw, nh);
            push_e(1'b0, 1'b0, 1'b1, 1'b1, addr[15:0], w, nw, nh);
        end else begin
            push_e(1'b0, 1'b0, 1'b1, 1'b0, addr[15:0], w, nw, nh);
        end
        m_paddr = addr[15:0]; m_pwrite = w; m_pwdata = nw; m_hrdata = nh;
        last = 2 + wr + waits;
        for (int k = 1; k <= last; k++) begin
            @(posedge HCLK);
            #1;
            HTRANS = 2'b11; HADDR = ~addr; HWRITE = ~w;
            HWDATA = (k == 1 && w) ? wdata : (32'hFFFF_0000 ^ k);
            PREADY  = (k < 2 + wr) ? 1'b1 : (k == last);
            PSLVERR = (k == last) ? err : 1'b1;
            PRDATA  = (k == last) ? rdata : (32'h0F0F_0000 ^ k);
        end
        if (err && SLVERR_EN) begin
            @(posedge HCLK);
            #1;
            PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5A5A_5A5A;
        end
        @(posedge HCLK);
        #1;
        idle_inputs();
        lat = cyc - a;
    endtask

    initial begin
        int lat;
        int lat2;
        HRESET = 1'b1; HWDATA = 32'h0;
        idle_inputs();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
        chk("rst_HRESP",     {31'b0, HRESP},     32'd0);
        chk("rst_HRDATA",    HRDATA,             32'h0);
        chk("rst_PADDR",     {16'b0, PADDR},     32'h0);
        chk("rst_PSEL",      {31'b0, PSEL},      32'd0);
        chk("rst_PENABLE",   {31'b0, PENABLE},   32'd0);
        chk("rst_PWRITE",    {31'b0, PWRITE},    32'd0);
        chk("rst_PWDATA",    PWDATA,             32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk_en = 1'b1;
        @(posedge HCLK); #1;

        // zero-wait read
        xfer(1'b0, 32'h0000_1234, 32'h0, 32'hCAFE_F00D, 0, 1'b0, lat);
        chk("rd_latency", lat, 32'd3);
        @(negedge HCLK);
        chk("rd_HRDATA",    HRDATA,             32'hCAFE_F00D);
        chk("rd_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
        chk("rd_PADDR",     {16'b0, PADDR},     32'h0000_1234);
        chk("rd_PWRITE",    {31'b0, PWRITE},    32'd0);
        @(posedge HCLK); #1;

        // write with two PREADY-low cycles
        xfer(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, lat);
        chk("wr_latency", lat, 32'd6);
        @(negedge HCLK);
        chk("wr_PWDATA",    PWDATA,             32'hDEAD_BEEF);
        chk("wr_PADDR",     {16'b0, PADDR},     32'h0000_0020);
        chk("wr_HRDATA_kept", HRDATA,           32'hCAFE_F00D);
        @(posedge HCLK); #1;

        // back-to-back: read presented in the DONE cycle of a write
        xfer(1'b1, 32'h0000_0010, 32'h0123_4567, 32'h0, 0, 1'b0, lat);
        xfer(1'b0, 32'h0000_0014, 32'h0, 32'h89AB_CDEF, 1, 1'b0, lat2);
        chk("b2b_lat1", lat, 32'd4);
        chk("b2b_lat2", lat2, 32'd4);
        @(negedge HCLK);
        chk("b2b_PADDR",  {16'b0, PADDR}, 32'h0000_0014);
        chk("b2b_HRDATA", HRDATA,         32'h89AB_CDEF);
        @(posedge HCLK); #1;

        // slave error on a read, then a write accepted straight away
        xfer(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_0BAD, 0, 1'b1, lat);
        chk("err_latency", lat, SLVERR_EN ? 32'd4 : 32'd3);
        xfer(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 32'h0, 0, 1'b0, lat2);
        chk("err_b2b_latency", lat2, 32'd4);
        @(negedge HCLK);
        chk("err_HRDATA", HRDATA, 32'h0BAD_0BAD);
        @(posedge HCLK); #1;

        // transfers that must be ignored: BUSY, HSEL=0, HREADY=0
        for (int v = 0; v < 3; v++) begin
            HSEL   = (v == 1) ? 1'b0 : 1'b1;
            HTRANS = (v == 0) ? 2'b01 : 2'b10;
            HREADY = (v == 2) ? 1'b0 : 1'b1;
            HADDR  = 32'h0000_0080; HWRITE = v[0];
            @(posedge HCLK); #1;
            idle_inputs();
            @(negedge HCLK);
            chk("ign_PSEL",      {31'b0, PSEL},      32'd0);
            chk("ign_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
            @(posedge HCLK); #1;
        end

        // reset while in ACCESS with the APB slave stalling
        chk_en = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0300; HWRITE = 1'b0; PREADY = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("mid_PENABLE", {31'b0, PENABLE}, 32'd1);
        #1;
        HRESET = 1'b1;
        #1;
        chk("rst2_PSEL",      {31'b0, PSEL},      32'd0);
        chk("rst2_PENABLE",   {31'b0, PENABLE},   32'd0);
        chk("rst2_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
        chk("rst2_HRESP",     {31'b0, HRESP},     32'd0);
        chk("rst2_HRDATA",    HRDATA,             32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        idle_inputs();
        q.delete();
        m_paddr = 16'h0; m_pwrite = 1'b0; m_pwdata = 32'h0; m_hrdata = 32'h0;
        chk_en = 1'b1;
        @(posedge HCLK); #1;

        xfer(1'b0, 32'h0000_0008, 32'h0, 32'h7654_3210, 0, 1'b0, lat);
        chk("post_rst_latency", lat, 32'd3);
        repeat (3) @(posedge HCLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
